// File: rtl/limiter_pkg.sv
// Shared types and helpers for the linked-channel peak limiter.
package limiter_pkg;

    typedef enum logic [1:0] {
        LIM_BYPASS = 2'b00,
        LIM_HARD   = 2'b01,
        LIM_SOFT   = 2'b10
    } lim_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEAK,
        ST_DIV,
        ST_ENV,
        ST_APPLY,
        ST_OUT
    } lim_state_e;

    // Cycles from the valid_in cycle to the valid_out cycle.
    function automatic int lim_latency(input int channels, input int gain_frac);
        return 2 * channels + gain_frac + 3;
    endfunction

    // Mode code 11 behaves as soft.
    function automatic lim_mode_e lim_decode_mode(input logic [1:0] m);
        lim_mode_e r;
        case (m)
            2'b00:   r = LIM_BYPASS;
            2'b01:   r = LIM_HARD;
            default: r = LIM_SOFT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lim_divider.sv
// Restoring divider producing the low Q_W quotient bits, one bit per cycle.
// The start cycle performs the first step; done is high in the Q_W-th cycle.
module lim_divider #(
    parameter int N_W = 30,
    parameter int D_W = 16,
    parameter int Q_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           done,
    output logic [Q_W-1:0] quotient
);

    localparam int C_W = $clog2(Q_W + 1);

    logic           active;
    logic [C_W-1:0] cnt;
    logic [D_W-1:0] rem, dvs, rem_src, dvs_src;
    logic [Q_W-1:0] bits, bits_src;
    logic [D_W:0]   trial;
    logic           ge;

    // Upper dividend bits seed the remainder; they are below the divisor
    // whenever the quotient is actually consumed, so Q_W steps suffice.
    always_comb begin
        rem_src  = rem;
        bits_src = bits;
        dvs_src  = dvs;
        if (start) begin
            rem_src  = D_W'(dividend >> Q_W);
            bits_src = dividend[Q_W-1:0];
            dvs_src  = divisor;
        end
        trial = {rem_src, bits_src[Q_W-1]};
        ge    = trial >= {1'b0, dvs_src};
    end

    assign done = active && (cnt == C_W'(Q_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= C_W'(1);
        end else if (active) begin
            cnt <= cnt + C_W'(1);
            if (done)
                active <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start || active) begin
            rem      <= ge ? D_W'(trial - {1'b0, dvs_src}) : trial[D_W-1:0];
            bits     <= bits_src << 1;
            dvs      <= dvs_src;
            quotient <= (quotient << 1) | Q_W'(ge);
        end
    end

endmodule

// File: rtl/multi_peak_limiter.sv
// Linked multi-channel limiter: bypass, hard clip, or soft envelope gain
// shared across all channels, processed one channel per cycle.
module multi_peak_limiter
    import limiter_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int CHANNELS      = 2,
    parameter int GAIN_FRAC     = 15,
    parameter int ATTACK_SHIFT  = 0,
    parameter int RELEASE_SHIFT = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [1:0]                mode,
    input  logic [WIDTH-1:0]          limit,
    input  logic                      valid_in,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic                      clr_overrun,
    output logic [CHANNELS*WIDTH-1:0] data_out,
    output logic                      valid_out,
    output logic                      busy,
    output logic                      overrun,
    output logic [GAIN_FRAC:0]        gain_out
);

    localparam int CW    = CHANNELS * WIDTH;
    localparam int WIDE  = WIDTH + GAIN_FRAC + 2;
    localparam int N_W   = WIDTH - 1 + GAIN_FRAC;
    localparam int CNT_W = $clog2(CHANNELS + 1);
    localparam logic [GAIN_FRAC:0] UNITY   = {1'b1, {GAIN_FRAC{1'b0}}};
    localparam logic [GAIN_FRAC:0] G_ONE   = {{GAIN_FRAC{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] x);
        logic [WIDTH-1:0] u;
        u = x;
        return x[WIDTH-1] ? -u : u;
    endfunction

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [WIDE-1:0] v,
                                                    input logic [WIDTH-1:0] lim);
        logic signed [WIDE-1:0] hi, lo, r;
        hi = $signed(WIDE'(lim));
        lo = -hi;
        r  = v;
        if (v > hi)
            r = hi;
        else if (v < lo)
            r = lo;
        return $signed(r[WIDTH-1:0]);
    endfunction

    function automatic logic signed [WIDTH-1:0] apply_ch(input logic signed [WIDTH-1:0] x,
                                                         input logic [GAIN_FRAC:0] g,
                                                         input lim_mode_e m,
                                                         input logic [WIDTH-1:0] lim);
        logic signed [WIDE-1:0] xw, gw, prod;
        logic signed [WIDTH-1:0] y;
        xw   = WIDE'(x);
        gw   = $signed(WIDE'(g));
        prod = (xw * gw) >>> GAIN_FRAC;
        case (m)
            LIM_BYPASS: y = x;
            LIM_HARD:   y = sat(xw, lim);
            default:    y = sat(prod, lim);
        endcase
        return y;
    endfunction

    // One envelope step toward the target; never stalls short of it.
    function automatic logic [GAIN_FRAC:0] env_step(input logic [GAIN_FRAC:0] g,
                                                    input logic [GAIN_FRAC:0] t);
        logic [GAIN_FRAC:0] step, r;
        step = '0;
        r    = g;
        if (t < g) begin
            step = (g - t) >> ATTACK_SHIFT;
            if (step == '0)
                step = G_ONE;
            r = g - step;
        end else if (t > g) begin
            step = (t - g) >> RELEASE_SHIFT;
            if (step == '0)
                step = G_ONE;
            r = g + step;
        end
        return r;
    endfunction

    lim_state_e         state;
    logic [CNT_W-1:0]   cnt;
    logic               last_ch;
    logic               div_go, div_done;
    logic [GAIN_FRAC:0] quo, target;
    lim_mode_e          mode_p0;
    logic [CW-1:0]      smp_p0, smp_rot, res_p2, res_next;
    logic [WIDTH-1:0]   lim_p0, peak_p1, x_mag, y_u;
    logic signed [WIDTH-1:0] x_cur, y_cur;

    assign last_ch  = (cnt == CNT_W'(CHANNELS - 1));
    assign x_cur    = $signed(smp_p0[WIDTH-1:0]);
    assign x_mag    = abs_mag(x_cur);
    assign smp_rot  = (smp_p0 >> WIDTH) | (smp_p0 << (CW - WIDTH));
    assign y_cur    = apply_ch(x_cur, gain_out, mode_p0, lim_p0);
    assign y_u      = y_cur;
    assign res_next = (res_p2 >> WIDTH) | (CW'(y_u) << (CW - WIDTH));
    assign target   = (peak_p1 <= lim_p0) ? UNITY : quo;

    lim_divider #(
        .N_W (N_W),
        .D_W (WIDTH),
        .Q_W (GAIN_FRAC + 1)
    ) u_div (
        .clk      (clk_in),
        .rst_n    (rst_in),
        .start    (div_go),
        .dividend ({lim_p0[WIDTH-2:0], {GAIN_FRAC{1'b0}}}),
        .divisor  (peak_p1),
        .done     (div_done),
        .quotient (quo)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            valid_out <= 1'b0;
            overrun   <= 1'b0;
            gain_out  <= UNITY;
            data_out  <= '0;
            div_go    <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            div_go    <= 1'b0;
            if (valid_in && busy)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
            case (state)
                ST_IDLE: if (valid_in) begin
                    state <= ST_PEAK;
                    busy  <= 1'b1;
                    cnt   <= '0;
                end
                ST_PEAK: if (last_ch) begin
                    state  <= ST_DIV;
                    div_go <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                ST_DIV: if (div_done) state <= ST_ENV;
                ST_ENV: begin
                    gain_out <= (mode_p0 == LIM_SOFT) ? env_step(gain_out, target) : UNITY;
                    cnt      <= '0;
                    state    <= ST_APPLY;
                end
                ST_APPLY: if (last_ch) begin
                    data_out  <= res_next;
                    valid_out <= 1'b1;
                    state     <= ST_OUT;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                ST_OUT: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Capture, then rotate samples through channel 0 in PEAK and APPLY.
    always_ff @(posedge clk_in) begin
        case (state)
            ST_IDLE: if (valid_in) begin
                smp_p0  <= data_in;
                lim_p0  <= limit[WIDTH-1] ? MAX_POS : limit;
                mode_p0 <= lim_decode_mode(mode);
                peak_p1 <= '0;
            end
            ST_PEAK: begin
                peak_p1 <= (x_mag > peak_p1) ? x_mag : peak_p1;
                smp_p0  <= smp_rot;
            end
            ST_APPLY: begin
                res_p2 <= res_next;
                smp_p0 <= smp_rot;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multi_peak_limiter.sv
// Directed bench for multi_peak_limiter: a vector table plus hand-written
// sequences for overrun, asynchronous reset and a four-channel build.
module tb_multi_peak_limiter;
    import limiter_pkg::*;

    localparam int LAT  = lim_latency(2, 15);
    localparam int LAT4 = lim_latency(4, 15);

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic [15:0] limit;
    logic        valid_in;
    logic [31:0] data_in;
    logic        clr_overrun;
    logic [31:0] data_out;
    logic        valid_out, busy, overrun;
    logic [15:0] gain_out;

    logic [1:0]  mode4;
    logic [15:0] limit4;
    logic        valid_in4;
    logic [63:0] data_in4;
    logic [63:0] data_out4;
    logic        valid_out4, busy4, overrun4;
    logic [15:0] gain_out4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_peak_limiter dut (
        .clk_in(clk), .rst_in(rst_n), .mode(mode), .limit(limit),
        .valid_in(valid_in), .data_in(data_in), .clr_overrun(clr_overrun),
        .data_out(data_out), .valid_out(valid_out), .busy(busy),
        .overrun(overrun), .gain_out(gain_out)
    );

    multi_peak_limiter #(.CHANNELS(4)) dut4 (
        .clk_in(clk), .rst_in(rst_n), .mode(mode4), .limit(limit4),
        .valid_in(valid_in4), .data_in(data_in4), .clr_overrun(1'b0),
        .data_out(data_out4), .valid_out(valid_out4), .busy(busy4),
        .overrun(overrun4), .gain_out(gain_out4)
    );

    typedef struct {
        logic [1:0] mode;
        int         limit;
        int         l, r;
        int         el, er, eg;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [1:0] m, input int lim, input int l, input int r,
                             output int ol, output int orr, output int og,
                             output int lat, output int bcnt);
        mode     = m;
        limit    = lim[15:0];
        data_in  = {r[15:0], l[15:0]};
        valid_in = 1'b1;
        tick;
        valid_in = 1'b0;
        lat = -1; bcnt = 0; ol = 0; orr = 0; og = 0;
        for (int c = 1; c <= 60; c++) begin
            if (busy) bcnt++;
            if (valid_out) begin
                lat = c;
                ol  = int'($signed(data_out[15:0]));
                orr = int'($signed(data_out[31:16]));
                og  = int'(gain_out);
                break;
            end
            tick;
        end
        tick;
    endtask

    task automatic frame_and_check(input string tag, input logic [1:0] m, input int lim,
                                   input int l, input int r,
                                   input int el, input int er, input int eg);
        int ol, orr, og, lat, bc;
        run_frame(m, lim, l, r, ol, orr, og, lat, bc);
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_busy_cycles"}, bc, LAT);
        check({tag, "_left"}, ol, el);
        check({tag, "_right"}, orr, er);
        check({tag, "_gain"}, og, eg);
        check({tag, "_idle_after"}, int'(busy) + int'(valid_out), 0);
    endtask

    initial begin
        int n_valid, ol, orr, lat;
        int ch4[4];
        int exp4[4];

        vecs[0]  = '{2'b01, 1000,   1500,  -2000,  1000,  -1000, 32768};
        vecs[1]  = '{2'b00, 0,    -32768,  32767, -32768,  32767, 32768};
        vecs[2]  = '{2'b01, 0,      500,   -500,     0,      0, 32768};
        vecs[3]  = '{2'b01, 40000, -32768, 32767, -32767,  32767, 32768};
        vecs[4]  = '{2'b10, 16384,  32767, -32768, 16383, -16384, 16384};
        vecs[5]  = '{2'b10, 16384,      0,      0,     0,      0, 17408};
        vecs[6]  = '{2'b10, 16384,  10000,  -3000,  5605,  -1682, 18368};
        vecs[7]  = '{2'b00, 500,     1234,     -5,  1234,     -5, 32768};
        vecs[8]  = '{2'b11, 8000,   16000,  -4000,  8000,  -2000, 16384};
        vecs[9]  = '{2'b10, 100,   -32768,      7,  -100,      0,   100};
        vecs[10] = '{2'b10, 0,         50,    -50,     0,      0,     0};
        vecs[11] = '{2'b10, 20000,    100,    200,     6,     12,  2048};
        vecs[12] = '{2'b10, 20000,     -1,      0,    -1,      0,  3968};
        vecs[13] = '{2'b10, 1000,    3000,  -1500,   403,   -202,  4402};
        vecs[14] = '{2'b01, 1000,    3000,  -1500,  1000,  -1000, 32768};
        vecs[15] = '{2'b10, 1000,    3000,  -1500,   999,   -500, 10922};
        vecs[16] = '{2'b01, 4095,    4096,      0,  4095,      0, 32768};
        vecs[17] = '{2'b10, 4095,    4096,      0,  4095,      0, 32760};
        vecs[18] = '{2'b10, 4095,       0,      0,     0,      0, 32761};

        rst_n = 1'b0; mode = 2'b00; limit = '0; valid_in = 1'b0; data_in = '0;
        clr_overrun = 1'b0; mode4 = 2'b00; limit4 = '0; valid_in4 = 1'b0; data_in4 = '0;
        repeat (3) tick;
        rst_n = 1'b1;
        tick;
        check("reset_data_out", int'(data_out), 0);
        check("reset_valid_out", int'(valid_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_gain", int'(gain_out), 32768);

        for (int i = 0; i < 19; i++)
            frame_and_check($sformatf("vec%0d", i), vecs[i].mode, vecs[i].limit,
                            vecs[i].l, vecs[i].r, vecs[i].el, vecs[i].er, vecs[i].eg);

        // Asynchronous reset in the middle of the divide phase.
        frame_and_check("pre_reset", 2'b10, 16384, 32767, -32768, 16383, -16384, 16384);
        mode = 2'b10; limit = 16'd1000; data_in = {16'd3000, 16'd3000};
        valid_in = 1'b1;
        tick;
        valid_in = 1'b0;
        repeat (9) tick;
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_data_out", int'(data_out), 0);
        check("async_rst_valid_out", int'(valid_out), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_gain", int'(gain_out), 32768);
        tick;
        tick;
        rst_n = 1'b1;
        n_valid = 0;
        for (int c = 0; c < 30; c++) begin
            if (valid_out) n_valid++;
            tick;
        end
        check("aborted_frame_no_valid", n_valid, 0);
        frame_and_check("post_reset", 2'b01, 1000, 1500, -2000, 1000, -1000, 32768);

        // Overrun: dropped frames while busy, clear racing a drop, then clear.
        mode = 2'b01; limit = 16'd1000; data_in = {16'hF830, 16'd1500};
        valid_in = 1'b1;
        tick;
        valid_in = 1'b0;
        mode = 2'b00; data_in = {16'd7, 16'd7};
        n_valid = 0; lat = -1; ol = 0; orr = 0;
        for (int c = 1; c <= 40; c++) begin
            if (valid_out) begin
                n_valid++;
                if (lat < 0) begin
                    lat = c;
                    ol  = int'($signed(data_out[15:0]));
                    orr = int'($signed(data_out[31:16]));
                end
            end
            if (c == 6) check("overrun_set", int'(overrun), 1);
            if (c == 8) check("overrun_clear_vs_drop", int'(overrun), 1);
            valid_in    = (c == 5) || (c == 7);
            clr_overrun = (c == 7);
            tick;
            valid_in    = 1'b0;
            clr_overrun = 1'b0;
        end
        check("overrun_valid_count", n_valid, 1);
        check("overrun_latency", lat, LAT);
        check("overrun_left", ol, 1000);
        check("overrun_right", orr, -1000);
        check("overrun_still_set", int'(overrun), 1);
        clr_overrun = 1'b1;
        tick;
        clr_overrun = 1'b0;
        check("overrun_cleared", int'(overrun), 0);

        // Four linked channels share one gain.
        ch4  = '{30000, 100, -201, 50};
        exp4 = '{15000, 50, -101, 25};
        mode4 = 2'b10; limit4 = 16'd15000;
        for (int k = 0; k < 4; k++)
            data_in4[16*k +: 16] = ch4[k][15:0];
        valid_in4 = 1'b1;
        tick;
        valid_in4 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            if (valid_out4) begin
                lat = c;
                for (int k = 0; k < 4; k++)
                    check($sformatf("ch4_out%0d", k), int'($signed(data_out4[16*k +: 16])), exp4[k]);
                check("ch4_gain", int'(gain_out4), 16384);
                break;
            end
            tick;
        end
        check("ch4_latency", lat, LAT4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_peak_limiter.md
Name: multi_peak_limiter

Overview:
Next-generation limiter for the audio effects chain, sitting after the mixer and before the output DAC path in the 11.29 MHz domain. It handles CHANNELS linked signed channels and accepts one frame per `valid_in` strobe. It offers bypass, hard-clip and soft (envelope gain-reduction) modes, and computes soft-mode gain with an iterative divider. All channels share one gain, so the stereo image is preserved.

Parameters:
- WIDTH, 16, signed sample width per channel.
- CHANNELS, 2, number of linked channels (≥1).
- GAIN_FRAC, 15, fractional bits of the unsigned gain; unity gain = 2^GAIN_FRAC.
- ATTACK_SHIFT, 0, attack smoothing shift; 0 means instant.
- RELEASE_SHIFT, 4, release smoothing shift.

Ports:
- clk_in  in  1  system clock, 11.29 MHz.
- rst_in  in  1  reset, asynchronous, active-low.
- mode  in  2  00 bypass, 01 hard, 10 soft, 11 treated as soft.
- limit  in  WIDTH  unsigned ceiling, internally clamped to 2^(WIDTH-1)-1.
- valid_in  in  1  one-cycle frame strobe.
- data_in  in  CHANNELS*WIDTH  packed signed samples; channel 0 in the LSBs.
- clr_overrun  in  1  clears the sticky overrun flag.
- data_out  out  CHANNELS*WIDTH  packed signed results.
- valid_out  out  1  one-cycle strobe, data_out valid.
- busy  out  1  high from capture until valid_out.
- overrun  out  1  sticky: a valid_in arrived while busy.
- gain_out  out  GAIN_FRAC+1  current envelope gain.

Behaviour:
- Reset (async, rst_in=0):
  - data_out=0, valid_out=0, busy=0, overrun=0, gain_out=2^GAIN_FRAC.
  - FSM returns to IDLE immediately, which also aborts any in-flight frame.
- Capture:
  - In IDLE, valid_in latches data_in, mode and limit.
  - busy rises the next cycle.
  - mode/limit changes mid-frame have no effect on the current frame.
- FSM states and durations:
  - IDLE.
  - PEAK: CHANNELS cycles. Computes peak = max |x| as a WIDTH-bit unsigned value; |−2^(WIDTH-1)| = 2^(WIDTH-1).
  - DIV: GAIN_FRAC+1 cycles. Divider computes floor(limit·2^GAIN_FRAC / peak).
  - ENV: 1 cycle.
  - APPLY: CHANNELS cycles.
  - OUT: 1 cycle, valid_out=1, back to IDLE.
- Latency:
  - Fixed and mode-independent: valid_out is asserted exactly 2·CHANNELS+GAIN_FRAC+3 cycles after the valid_in cycle (22 with defaults).
  - DIV always runs, even when its result is unused.
- Target gain: t = 2^GAIN_FRAC if peak ≤ limit (this covers peak=0); otherwise t = quotient.
- ENV update (soft mode only):
  - If t < g: g ← g − ((g−t)>>ATTACK_SHIFT).
  - If t > g: g ← g + ((t−g)>>RELEASE_SHIFT).
  - If the shifted step is 0 while g≠t, step by 1 toward t.
  - In bypass or hard mode, g ← 2^GAIN_FRAC.
- APPLY, per mode:
  - Bypass: y = x.
  - Hard: y = clamp(x, −limit, +limit).
  - Soft: y = clamp((x·g) >>> GAIN_FRAC, −limit, +limit), using a signed product with an arithmetic shift (floor).
  - limit=0 forces soft/hard outputs to 0.
- Output registers:
  - data_out is updated only in OUT and held otherwise.
  - gain_out reflects g after ENV.
- Overrun and clearing:
  - valid_in while busy is dropped and sets overrun; the in-flight frame is unaffected.
  - clr_overrun clears overrun; if clr_overrun and a dropped valid_in occur in the same cycle, overrun stays set.

Decomposition:
- Package limiter_pkg:
  - mode enum (LIM_BYPASS, LIM_HARD, LIM_SOFT).
  - FSM state enum.
  - Function computing the latency constant.
- Sub-module lim_divider:
  - Unsigned restoring divider with start/done handshake.
  - Parameters N_W (dividend width) and Q_W = GAIN_FRAC+1.
  - Exactly Q_W cycles from start to done.
  - Callers never present divisor 0; the caller guarantees peak > limit ≥ 0 when the quotient is used.

Test Plan:
- Hard mode, limit=1000, frame L=1500, R=−2000 → 22 cycles later L=1000, R=−1000, gain_out=32768.
- Bypass mode, L=−32768, R=32767 → outputs identical; latency 22; busy high for cycles 1–22.
- Soft mode, limit=16384, L=32767, R=−32768:
  - Expect peak=32768, target=16384, gain_out=16384.
  - Expect L=16383, R=−16384.
  - Follow with a zero frame → gain_out=17408 (release step 1024).
- Overrun: second valid_in 5 cycles after the first → overrun=1, first frame's output correct, only one valid_out; then clr_overrun → overrun=0.
- Reset mid-DIV: pull rst_in low at cycle 10 → data_out=0, valid_out=0, busy=0, gain_out=32768 asynchronously; a subsequent frame behaves normally.
- CHANNELS=4, soft mode, one channel at 30000, others small, limit=15000 → all four channels scaled by the same gain (about 16384); latency 2·4+18 = 26.
